hash_round_sequencer: RTL and testbench
=======================================

Name: hash_round_sequencer

Overview:
Per-block round sequencer for the hash datapath, one stage upstream of the K-constant chooser. It accepts a start request with an opcode (MD5, SHA_1, SHA_256, OPCODE_RESERVE) and steps the round index through the algorithm's round count. Each round it drives `round`, `quad_funct` and the latched `opcode` straight into the K chooser. It also drives the message-word index, schedule enable and init/final-add/done strobes consumed by the compression datapath.

Parameters:
- MD5_ROUNDS, 64, rounds per MD5 block
- SHA1_ROUNDS, 80, rounds per SHA-1 block
- SHA256_ROUNDS, 64, rounds per SHA-256 block; also used for OPCODE_RESERVE

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to hash one block; accepted only in IDLE
- opcode_in  in  2  algorithm select; encoding from definitions package
- stall  in  1  freezes round progression while high
- busy  out  1  high in every state except IDLE
- init_state  out  1  one-cycle pulse in LOAD; datapath loads working vars from digest
- round_valid  out  1  high in ROUNDS state
- round  out  8  current round index, to K chooser
- quad_funct  out  2  round-group index, to K chooser and F-function mux
- opcode  out  2  opcode latched at start acceptance, to K chooser
- msg_idx  out  4  message word index for current round
- sched_en  out  1  SHA round at or above 16; datapath uses the scheduled W word
- last_round  out  1  round_valid and round == N-1
- final_add  out  1  one-cycle pulse in FINAL; datapath adds working vars into digest
- done  out  1  one-cycle pulse in DONE

Behaviour:
- N is the round count for the latched opcode: MD5→MD5_ROUNDS, SHA_1→SHA1_ROUNDS, SHA_256/OPCODE_RESERVE→SHA256_ROUNDS.
- FSM states: IDLE, LOAD, ROUNDS, FINAL, DONE.
- IDLE:
  - When start=1, latch opcode_in into opcode, clear round to 0, go to LOAD.
  - start in any other state is ignored, including DONE; start in DONE is not queued.
- LOAD: lasts exactly one cycle and is not stallable. init_state=1. Goes to ROUNDS.
- ROUNDS:
  - round_valid=1.
  - If stall=1, round and all outputs hold.
  - Else if round==N-1, go to FINAL; round holds N-1.
  - Else round increments by 1. Round never wraps.
- FINAL: one cycle, final_add=1, not stallable. Goes to DONE.
- DONE: one cycle, done=1. Goes to IDLE.
- Latency with no stalls: start sampled at edge 0 → LOAD in cycle 1, rounds 0..N-1 in cycles 2..N+1, FINAL in cycle N+2, done in cycle N+3. Each stalled cycle adds one cycle.
- quad_funct:
  - MD5: round[5:4].
  - SHA_1: 0 for rounds 0-19, 1 for 20-39, 2 for 40-59, 3 for 60-79. Computed by comparison, not division.
  - SHA_256/reserved: 0.
- msg_idx for MD5 (arithmetic mod 16, i=round):
  - i<16: i
  - i<32: (5i+1) mod 16
  - i<48: (3i+5) mod 16
  - else: 7i mod 16
- msg_idx for SHA: round[3:0]. sched_en = SHA opcode and round>=16. For MD5, sched_en=0.
- Outputs outside ROUNDS: round, quad_funct, msg_idx and sched_en keep their last value in FINAL/DONE, and read 0 after reset.
- Reset values: state IDLE, all outputs 0 including opcode.
- Reset asserted mid-block: next cycle is IDLE, all outputs 0, no done pulse. A start present in the same cycle as reset is dropped.
- stall is ignored outside ROUNDS.

Optional Feature:
- Macro: HASH_SEQ_PERF_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0], the count of stalled ROUNDS cycles in the current or most recent block.
  - Cleared on start acceptance; saturates at 16'hFFFF; reset to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- MD5 start, stall=0 → init_state in cycle 1, round 0..63 in cycles 2..65, final_add in cycle 66, done in cycle 67.
- MD5 index and group checks:
  - msg_idx at round 17 = 6, round 33 = 8, round 50 = 14.
  - quad_funct at rounds 15/16/47/48 = 0/1/2/3.
- SHA_1 block → 80 rounds, done in cycle 83.
  - quad_funct at rounds 19/20/59/60 = 0/1/2/3.
  - sched_en first high at round 16.
  - last_round high only at round 79.
- SHA_256 with stall=1 for 5 cycles at round 10 → round holds 10 for 5 extra cycles, done in cycle 72; stall_cnt=5 when the feature is enabled.
- start pulsed during ROUNDS and during DONE → ignored. start in the cycle after done → new block, opcode re-latched.
- reset asserted at SHA_1 round 40 → next cycle IDLE, busy=0, round=0, no done. A following start runs a full 80-round block.

Source files
------------

// File: rtl/hash_round_sequencer.sv
// Per-block round sequencer: steps the round index for MD5/SHA-1/SHA-256 and
// drives K-chooser and compression-datapath controls. Optional stall counter: HASH_SEQ_PERF_CNT_EN.
module hash_round_sequencer #(
  parameter int MD5_ROUNDS    = 64,
  parameter int SHA1_ROUNDS   = 80,
  parameter int SHA256_ROUNDS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] opcode_in,
  input  logic       stall,
  output logic       busy,
  output logic       init_state,
  output logic       round_valid,
  output logic [7:0] round,
  output logic [1:0] quad_funct,
  output logic [1:0] opcode,
  output logic [3:0] msg_idx,
  output logic       sched_en,
  output logic       last_round,
  output logic       final_add,
  output logic       done
`ifdef HASH_SEQ_PERF_CNT_EN
  ,output logic [15:0] stall_cnt
`endif
);

  localparam logic [1:0] OP_MD5   = 2'd0;
  localparam logic [1:0] OP_SHA1  = 2'd1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUNDS, S_FINAL, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] round_q, round_d;
  logic [1:0] opcode_q, opcode_d, quad_q, quad_d;
  logic [3:0] msg_q, msg_d;
  logic       sched_q, sched_d, last_q, last_d;
  logic       busy_q, busy_d, init_q, init_d, rv_q, rv_d;
  logic       fin_q, fin_d, done_q, done_d;

  function automatic logic [7:0] last_idx(input logic [1:0] op);
    case (op)
      OP_MD5:  return 8'(MD5_ROUNDS - 1);
      OP_SHA1: return 8'(SHA1_ROUNDS - 1);
      default: return 8'(SHA256_ROUNDS - 1);
    endcase
  endfunction

  function automatic logic [1:0] quad_of(input logic [7:0] i, input logic [1:0] op);
    if (op == OP_MD5) return i[5:4];
    if (op != OP_SHA1) return 2'd0;
    if (i < 8'd20) return 2'd0;
    if (i < 8'd40) return 2'd1;
    if (i < 8'd60) return 2'd2;
    return 2'd3;
  endfunction

  // MD5 message-word permutation; all arithmetic is naturally mod 16 in 4 bits
  function automatic logic [3:0] msg_of(input logic [7:0] i, input logic [1:0] op);
    logic [3:0] r;
    r = i[3:0];
    if (op != OP_MD5) return r;
    if (i < 8'd16) return r;
    if (i < 8'd32) return r * 4'd5 + 4'd1;
    if (i < 8'd48) return r * 4'd3 + 4'd5;
    return r * 4'd7;
  endfunction

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    opcode_d = opcode_q;
    quad_d   = quad_q;
    msg_d    = msg_q;
    sched_d  = sched_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_LOAD;
        opcode_d = opcode_in;
        round_d  = 8'd0;
      end
      S_LOAD:   state_d = S_ROUNDS;
      S_ROUNDS: if (!stall) begin
        if (round_q == last_idx(opcode_q)) state_d = S_FINAL;
        else round_d = round_q + 8'd1;
      end
      S_FINAL:  state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
    // Round-derived outputs only track the index while a block is active; they hold afterwards.
    if (state_d == S_LOAD || state_d == S_ROUNDS) begin
      quad_d  = quad_of(round_d, opcode_d);
      msg_d   = msg_of(round_d, opcode_d);
      sched_d = (opcode_d != OP_MD5) && (round_d >= 8'd16);
    end
    busy_d = (state_d != S_IDLE);
    init_d = (state_d == S_LOAD);
    rv_d   = (state_d == S_ROUNDS);
    last_d = (state_d == S_ROUNDS) && (round_d == last_idx(opcode_d));
    fin_d  = (state_d == S_FINAL);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      round_q  <= '0;
      opcode_q <= '0;
      quad_q   <= '0;
      msg_q    <= '0;
      sched_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      init_q   <= 1'b0;
      rv_q     <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      opcode_q <= opcode_d;
      quad_q   <= quad_d;
      msg_q    <= msg_d;
      sched_q  <= sched_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      init_q   <= init_d;
      rv_q     <= rv_d;
      fin_q    <= fin_d;
      done_q   <= done_d;
    end
  end

`ifdef HASH_SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && start) stall_cnt_d = '0;
    else if (state_q == S_ROUNDS && stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign busy        = busy_q;
  assign init_state  = init_q;
  assign round_valid = rv_q;
  assign round       = round_q;
  assign quad_funct  = quad_q;
  assign opcode      = opcode_q;
  assign msg_idx     = msg_q;
  assign sched_en    = sched_q;
  assign last_round  = last_q;
  assign final_add   = fin_q;
  assign done        = done_q;

endmodule

// File: tb/tb_hash_round_sequencer.sv
// Directed bench for hash_round_sequencer: per-cycle timeline model plus a
// scoreboard of expected done events, checked with immediate assertions.
module tb_hash_round_sequencer;

  localparam logic [1:0] OP_MD5 = 2'd0, OP_SHA1 = 2'd1, OP_SHA256 = 2'd2, OP_RES = 2'd3;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0;
  logic [1:0] opcode_in = 2'd0;
  logic       busy, init_state, round_valid, sched_en, last_round, final_add, done;
  logic [7:0] round;
  logic [1:0] quad_funct, opcode;
  logic [3:0] msg_idx;
`ifdef HASH_SEQ_PERF_CNT_EN
  logic [15:0] stall_cnt;
`endif

  hash_round_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode_in(opcode_in), .stall(stall),
    .busy(busy), .init_state(init_state), .round_valid(round_valid), .round(round),
    .quad_funct(quad_funct), .opcode(opcode), .msg_idx(msg_idx), .sched_en(sched_en),
    .last_round(last_round), .final_add(final_add), .done(done)
`ifdef HASH_SEQ_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] op; int done_c; } sb_t;
  sb_t sb_q[$];

  int n_total = 0, n_pass = 0, n_fail = 0;
  logic [3:0] cap_msg[256];
  logic [1:0] cap_quad[256];
  int first_sched, last_cnt, last_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int nrounds(input logic [1:0] op);
    return (op == OP_SHA1) ? 80 : 64;
  endfunction

  // Round shown in cycle c after the start edge, given a stall of l cycles at round s.
  function automatic int exp_round(input int c, input int n, input int s, input int l);
    int k;
    if (c < 2) return 0;
    k = c - 2;
    if (k > n - 1 + l) return n - 1;
    if (l == 0 || k <= s) return k;
    return (k - l > s) ? k - l : s;
  endfunction

  function automatic int exp_msg(input int r, input logic [1:0] op);
    if (op != OP_MD5) return r % 16;
    if (r < 16) return r;
    if (r < 32) return (5 * r + 1) % 16;
    if (r < 48) return (3 * r + 5) % 16;
    return (7 * r) % 16;
  endfunction

  function automatic int exp_quad(input int r, input logic [1:0] op);
    if (op == OP_MD5) return (r / 16) % 4;
    if (op == OP_SHA1) return r / 20;
    return 0;
  endfunction

  // Entered and left at a negedge; start is presented for the edge that ends the current cycle.
  task automatic run_block(input logic [1:0] op, input int s, input int l, input bit pulse);
    int n, dc, er;
    bit in_r;
    sb_t e;
    n  = nrounds(op);
    dc = n + 3 + l;
    e.op = op; e.done_c = dc;
    sb_q.push_back(e);
    first_sched = -1; last_cnt = 0; last_at = -1;
    opcode_in = op;
    start = 1'b1;
    for (int c = 1; c <= dc + 1; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) opcode_in = ~op;
      er   = exp_round(c, n, s, l);
      in_r = (c >= 2) && (c <= n + 1 + l);
      chk("busy",        32'(busy),        32'(c <= dc));
      chk("init_state",  32'(init_state),  32'(c == 1));
      chk("round_valid", 32'(round_valid), 32'(in_r));
      chk("round",       32'(round),       32'(er));
      chk("opcode",      32'(opcode),      32'(op));
      chk("msg_idx",     32'(msg_idx),     32'(exp_msg(er, op)));
      chk("quad_funct",  32'(quad_funct),  32'(exp_quad(er, op)));
      chk("sched_en",    32'(sched_en),    32'(op != OP_MD5 && er >= 16));
      chk("last_round",  32'(last_round),  32'(in_r && er == n - 1));
      chk("final_add",   32'(final_add),   32'(c == n + 2 + l));
      chk("done",        32'(done),        32'(c == dc));
      if (round_valid === 1'b1) begin
        cap_msg[round]  = msg_idx;
        cap_quad[round] = quad_funct;
        if (sched_en === 1'b1 && first_sched < 0) first_sched = int'(round);
        if (last_round === 1'b1) begin last_cnt++; last_at = int'(round); end
      end
      if (done === 1'b1) begin
        if (sb_q.size() == 0) chk("sb_unexpected_done", 32'(1), 32'(0));
        else begin
          e = sb_q.pop_front();
          chk("sb_done_cycle", 32'(c), 32'(e.done_c));
          chk("sb_done_opcode", 32'(opcode), 32'(e.op));
        end
      end
      start = pulse && (c == 20 || c == dc);
      stall = (l > 0) && (c >= 2 + s) && (c < 2 + s + l);
    end
    start = 1'b0;
    stall = 1'b0;
    if (sb_q.size() != 0) begin
      chk("sb_done_timeout", 32'(sb_q.size()), 32'(0));
      sb_q.delete();
    end
  endtask

  initial begin
    bit found;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   32'(busy),        32'(0));
    chk("rst_round",  32'(round),       32'(0));
    chk("rst_opcode", 32'(opcode),      32'(0));
    chk("rst_rv",     32'(round_valid), 32'(0));
    chk("rst_done",   32'(done),        32'(0));
    chk("rst_msg",    32'(msg_idx),     32'(0));
    reset = 1'b0;
    @(posedge clk); @(negedge clk);

    run_block(OP_MD5, 0, 0, 1'b0);
    chk("md5_msg17",  32'(cap_msg[17]),  32'(6));
    chk("md5_msg33",  32'(cap_msg[33]),  32'(8));
    chk("md5_msg50",  32'(cap_msg[50]),  32'(14));
    chk("md5_quad15", 32'(cap_quad[15]), 32'(0));
    chk("md5_quad16", 32'(cap_quad[16]), 32'(1));
    chk("md5_quad47", 32'(cap_quad[47]), 32'(2));
    chk("md5_quad48", 32'(cap_quad[48]), 32'(3));
    chk("md5_sched_never", 32'(first_sched), 32'(-1));

    // start pulses during ROUNDS and DONE must be ignored
    run_block(OP_SHA1, 0, 0, 1'b1);
    chk("sha1_quad19",   32'(cap_quad[19]), 32'(0));
    chk("sha1_quad20",   32'(cap_quad[20]), 32'(1));
    chk("sha1_quad59",   32'(cap_quad[59]), 32'(2));
    chk("sha1_quad60",   32'(cap_quad[60]), 32'(3));
    chk("sha1_sched16",  32'(first_sched),  32'(16));
    chk("sha1_last_cnt", 32'(last_cnt),     32'(1));
    chk("sha1_last_at",  32'(last_at),      32'(79));

    // back-to-back start in the cycle after done, with a 5-cycle stall at round 10
    run_block(OP_SHA256, 10, 5, 1'b0);
`ifdef HASH_SEQ_PERF_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(5));
`endif
    run_block(OP_RES, 0, 0, 1'b0);
    chk("res_last_at", 32'(last_at), 32'(63));

    // reset in the middle of a SHA-1 block
    opcode_in = OP_SHA1;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (round_valid === 1'b1 && round === 8'd40) begin found = 1'b1; break; end
      @(posedge clk); @(negedge clk);
    end
    chk("mid_reach_r40", 32'(found), 32'(1));
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("mid_busy",   32'(busy),        32'(0));
    chk("mid_round",  32'(round),       32'(0));
    chk("mid_rv",     32'(round_valid), 32'(0));
    chk("mid_opcode", 32'(opcode),      32'(0));
    chk("mid_quad",   32'(quad_funct),  32'(0));
    chk("mid_done",   32'(done),        32'(0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("mid_idle_busy", 32'(busy), 32'(0));
      chk("mid_idle_done", 32'(done), 32'(0));
    end
    run_block(OP_SHA1, 0, 0, 1'b0);
    chk("post_rst_last_at", 32'(last_at), 32'(79));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
